div_ctrl: RTL and testbench

Multi-cycle RV64M divide sequencer that sits beside the EXE stage's single-cycle ALU and multiplier. It covers DIV/DIVU/REM/REMU and the W variants. It latches the operands, runs a radix-2 restoring shift-subtract loop one bit per cycle, applies sign fix-up, then holds the result until EXE consumes it. EXE stalls on it: es_ready_go = !(es_valid && is_div) || div_done.

---
 rtl/div_ctrl_if.sv | 27 ++
 rtl/div_ctrl.sv | 139 +++++++++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// EXE <-> divide sequencer handshake: op request, flush/ack controls and result return.
interface div_ctrl_if #(
    parameter int XLEN = 64
);
    logic            div_valid;
    logic            div_signed;
    logic            div_rem;
    logic            div_word;
    logic [XLEN-1:0] div_src1;
    logic [XLEN-1:0] div_src2;
    logic            flush;
    logic            res_ack;
    logic            div_ready;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    modport master (
        output div_valid, div_signed, div_rem, div_word, div_src1, div_src2, flush, res_ack,
        input  div_ready, div_busy, div_done, div_result
    );

    modport slave (
        input  div_valid, div_signed, div_rem, div_word, div_src1, div_src2, flush, res_ack,
        output div_ready, div_busy, div_done, div_result
    );
endinterface

// File: rtl/div_ctrl.sv
// RV64M multi-cycle divider: radix-2 restoring loop on magnitudes, sign fix-up,
// result held in DONE until EXE acknowledges it.
module div_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic       clk,
    input logic       reset,
    div_ctrl_if.slave dif
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN32 = {{(XLEN-31){1'b1}}, 31'b0};

    state_e            state_q, state_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dsr_q, dsr_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rem_op_q, rem_op_d;
    logic              word_q, word_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic [XLEN-1:0] op1, op2, abs1, abs2, spec_raw, spec_res;
    logic            s1, s2, div_zero, ovf;
    logic [XLEN:0]   rem_sh, diff;
    logic            no_borrow;
    logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;

    // W ops see only bits [31:0], widened per signedness so the loop always runs on 64-bit values
    assign op1 = dif.div_word ? (dif.div_signed ? {{(XLEN-32){dif.div_src1[31]}}, dif.div_src1[31:0]}
                                                : {{(XLEN-32){1'b0}}, dif.div_src1[31:0]})
                              : dif.div_src1;
    assign op2 = dif.div_word ? (dif.div_signed ? {{(XLEN-32){dif.div_src2[31]}}, dif.div_src2[31:0]}
                                                : {{(XLEN-32){1'b0}}, dif.div_src2[31:0]})
                              : dif.div_src2;
    assign s1       = dif.div_signed & op1[XLEN-1];
    assign s2       = dif.div_signed & op2[XLEN-1];
    assign abs1     = s1 ? -op1 : op1;
    assign abs2     = s2 ? -op2 : op2;
    assign div_zero = (op2 == '0);
    assign ovf      = dif.div_signed && (op2 == {XLEN{1'b1}}) && (op1 == (dif.div_word ? MIN32 : MIN64));
    assign spec_raw = div_zero ? (dif.div_rem ? op1 : {XLEN{1'b1}})
                               : (dif.div_rem ? '0 : op1);
    assign spec_res = dif.div_word ? {{(XLEN-32){spec_raw[31]}}, spec_raw[31:0]} : spec_raw;

    // One restoring step: the dividend bit enters the partial remainder from the top of quo
    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_sh - {1'b0, dsr_q};
    assign no_borrow = ~diff[XLEN];

    assign q_fix   = qneg_q ? -quo_q : quo_q;
    assign r_fix   = rneg_q ? -rem_q : rem_q;
    assign sel_fix = rem_op_q ? r_fix : q_fix;
    assign fix_res = word_q ? {{(XLEN-32){sel_fix[31]}}, sel_fix[31:0]} : sel_fix;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        rem_op_d = rem_op_q;
        word_d   = word_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        case (state_q)
            S_IDLE: begin
                if (dif.div_valid && !dif.flush) begin
                    rem_op_d = dif.div_rem;
                    word_d   = dif.div_word;
                    qneg_d   = s1 ^ s2;
                    rneg_d   = s1;
                    rem_d    = '0;
                    // W dividend is left-aligned so 32 shifts consume exactly its bits
                    quo_d    = dif.div_word ? {abs1[31:0], {(XLEN-32){1'b0}}} : abs1;
                    dsr_d    = abs2;
                    cnt_d    = dif.div_word ? CNT_W'(31) : CNT_W'(XLEN-1);
                    if (div_zero || ovf) begin
                        res_d   = spec_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], no_borrow};
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                if (!dif.flush) res_d = fix_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (dif.res_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (dif.flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            rem_op_q <= 1'b0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            rem_op_q <= rem_op_d;
            word_q   <= word_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign dif.div_ready  = (state_q == S_IDLE);
    assign dif.div_busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign dif.div_done   = (state_q == S_DONE);
    assign dif.div_result = res_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed + random check of div_ctrl against RISC-V divide semantics and latency rules.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_ctrl_if #(.XLEN(64)) dif ();
    div_ctrl #(.XLEN(64), .CNT_W(7)) dut (.clk(clk), .reset(reset), .dif(dif.slave));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic s, input logic r, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, o32;
        logic [63:0] q64, r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
            else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            o32 = r ? r32 : q32;
            return {{32{o32[31]}}, o32};
        end
        if (b == 0) begin q64 = '1; r64 = a; end
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = '0; end
        else if (s) begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); end
        else begin q64 = a / b; r64 = a % b; end
        return r ? r64 : q64;
    endfunction

    function automatic int ref_lat(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            if (b[31:0] == 0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
            return 34;
        end
        if (b == 0 || (s && a == 64'h8000_0000_0000_0000 && b == '1)) return 1;
        return 66;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 20));
            1: return -64'($urandom_range(0, 20));
            2: return {$urandom, $urandom};
            3: return {32'($urandom), 32'h8000_0000};
            4: return ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : '1;
            default: return 64'($urandom);
        endcase
    endfunction

    // Drive an op #1 after a rising edge; returns after the accept edge, sampled #1 later.
    task automatic start_op(input logic s, input logic r, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
        chk("ready_before_accept", 64'(dif.div_ready), 64'd1);
        dif.div_valid = 1'b1; dif.div_signed = s; dif.div_rem = r; dif.div_word = w;
        dif.div_src1 = a; dif.div_src2 = b;
        @(posedge clk); #1;
        dif.div_valid = 1'b0;
        dif.div_src1 = {$urandom, $urandom};
        dif.div_src2 = {$urandom, $urandom};
    endtask

    task automatic run_op(input string tag, input logic s, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp_res;
        int          exp_lat, lat;
        logic        busy_bad, stable_bad;
        exp_res = ref_res(s, r, w, a, b);
        exp_lat = ref_lat(s, w, a, b);
        start_op(s, r, w, a, b);
        lat = 1; busy_bad = 1'b0;
        while (dif.div_done !== 1'b1 && lat < 120) begin
            if (dif.div_busy !== 1'b1 || dif.div_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, "_result"}, dif.div_result, exp_res);
        stable_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (dif.div_done !== 1'b1 || dif.div_ready !== 1'b0 || dif.div_busy !== 1'b0 ||
                dif.div_result !== exp_res) stable_bad = 1'b1;
        end
        chk({tag, "_hold"}, 64'(stable_bad), 64'd0);
        // a request in the ack cycle must not be taken
        dif.res_ack = 1'b1; dif.div_valid = 1'b1;
        @(posedge clk); #1;
        dif.res_ack = 1'b0; dif.div_valid = 1'b0;
        chk({tag, "_ack_state"}, {61'd0, dif.div_done, dif.div_ready, dif.div_busy}, 64'b010);
    endtask

    initial begin
        logic [63:0] held;
        logic        done_seen;
        reset = 1'b1;
        dif.div_valid = 0; dif.div_signed = 0; dif.div_rem = 0; dif.div_word = 0;
        dif.div_src1 = 0; dif.div_src2 = 0; dif.flush = 0; dif.res_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {60'd0, dif.div_ready, dif.div_busy, dif.div_done, 1'b0}, 64'b1000);
        chk("reset_result", dif.div_result, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("divu_100_7", 0, 0, 0, 64'd100, 64'd7, 0);
        run_op("remu_100_7", 0, 1, 0, 64'd100, 64'd7, 1);
        run_op("rem_m7_2",   1, 1, 0, -64'sd7, 64'd2, 0);
        run_op("div_m7_2",   1, 0, 0, -64'sd7, 64'd2, 0);
        run_op("divw_ovf",   1, 0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        run_op("divu_zero",  0, 0, 0, 64'd77, 64'd0, 0);
        run_op("remu_zero",  0, 1, 0, 64'd5, 64'd0, 0);
        run_op("div_ovf64",  1, 0, 0, 64'h8000_0000_0000_0000, '1, 0);
        run_op("divuw_sext", 0, 0, 1, 64'hFFFF_FFFE, 64'd1, 0);
        run_op("remw_neg",   1, 1, 1, 64'h1234_5678_FFFF_FFF9, 64'h0000_0000_0000_0002, 0);
        run_op("ack_hold5",  0, 0, 0, 64'd1000, 64'd9, 5);
        chk("ack_hold5_expect", ref_res(0, 0, 0, 64'd1000, 64'd9), 64'd111);

        // flush on the 10th CALC cycle; the killed op must never signal done
        held = dif.div_result;
        start_op(0, 0, 0, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        #1;
        chk("flush_pre_busy", 64'(dif.div_busy), 64'd1);
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush = 1'b0;
        chk("flush_idle", {61'd0, dif.div_ready, dif.div_busy, dif.div_done}, 64'b100);
        done_seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (dif.div_done !== 1'b0) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 64'(done_seen), 64'd0);
        chk("flush_result_kept", dif.div_result, held);
        run_op("after_flush_9_3", 0, 0, 0, 64'd9, 64'd3, 0);

        // flush together with a request in IDLE: not accepted
        dif.div_valid = 1'b1; dif.flush = 1'b1; dif.div_src1 = 64'd50; dif.div_src2 = 64'd5;
        @(posedge clk); #1;
        dif.div_valid = 1'b0; dif.flush = 1'b0;
        chk("flush_valid_idle", {61'd0, dif.div_ready, dif.div_busy, dif.div_done}, 64'b100);

        for (int n = 0; n < 30; n++) begin
            logic        s, r, w;
            logic [63:0] a, b;
            s = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
            a = rnd_operand(); b = rnd_operand();
            run_op($sformatf("rnd%0d", n), s, r, w, a, b, $urandom_range(0, 2));
        end

        // reset in the middle of CALC
        start_op(1, 0, 0, 64'd12345, 64'd17);
        repeat (5) @(posedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_state", {61'd0, dif.div_ready, dif.div_busy, dif.div_done}, 64'b100);
        chk("midreset_result", dif.div_result, 64'd0);
        run_op("post_reset", 1, 1, 0, 64'd12345, -64'sd17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
